cp0_regfile: RTL and testbench
==============================

Name: cp0_regfile

Overview:
- Coprocessor-0 register file and exception/interrupt controller, directly downstream of the alpha-pipe ALU.
- Consumes the ALU's cop0_addr/cop0_wen/write data and the commit-stage exception signals; returns cop0_data for MFC0.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC; generates the interrupt request and the exception/ERET redirect PC for the fetch stage.

Parameters:
- VEC_BOOT, 32'hBFC0_0380, exception vector used when Status.BEV=1
- VEC_NORM, 32'h8000_0180, exception vector used when Status.BEV=0

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cop0_addr  in  8  {rd, sel} register address from ALU
- cop0_wen  in  1  MTC0 write enable
- cop0_wdata  in  32  MTC0 data
- cop0_data  out  32  combinational read data for MFC0
- exp_valid  in  1  exception committed this cycle
- exp_code  in  5  ExcCode (Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12)
- exp_pc  in  32  PC of faulting instruction
- exp_bd  in  1  faulting instruction is in a delay slot
- exp_badvaddr  in  32  faulting address for AdEL/AdES
- exp_eret  in  1  ERET committed this cycle
- hw_int  in  6  external hardware interrupt lines, level-sensitive
- int_req  out  1  interrupt pending and enabled
- redirect_valid  out  1  flush pipeline and fetch from redirect_pc
- redirect_pc  out  32  target PC
- status_o  out  32  current Status
- epc_o  out  32  current EPC

Behaviour:
- Register map ({rd,sel}): BadVAddr=8'h40, Count=8'h48, Compare=8'h58, Status=8'h60, Cause=8'h68, EPC=8'h70. Any other address reads 0; writes to it are ignored.
- Reads are combinational from current state. An MTC0 becomes visible the cycle after cop0_wen.

Reset values:
- Status=32'h0040_0000 (BEV=1).
- Cause, EPC, BadVAddr, Count, Compare = 0.
- Count phase bit = 0.
- redirect_valid=0, int_req=0.

Writable fields:
- Status: IM[15:8], EXL[1], IE[0]. BEV[22] is read-only 1; all other bits read 0.
- Cause: IP[9:8] only.
- Count, Compare, EPC: full 32 bits. BadVAddr: read-only.

Cause fields:
- Cause.IP[15:10] <= hw_int each cycle, except IP[15] <= hw_int[5] | TI.
- TI is Cause[30].

Count and timer:
- A phase bit toggles every cycle. Count increments when phase=1, so Count advances once per 2 cycles and wraps 32'hFFFF_FFFF -> 0.
- An MTC0 to Count loads the written value, overrides the increment, and clears phase.
- TI sets when Count==Compare (registered, sticky).
- An MTC0 to Compare clears TI. If the clear and a match occur in the same cycle, the clear wins.

Interrupt request:
- int_req = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]), combinational.

Exception (exp_valid=1):
- If EXL=0: EPC <= exp_bd ? exp_pc-4 : exp_pc, and Cause.BD[31] <= exp_bd.
- If EXL=1: EPC and BD are unchanged.
- Always: Cause.ExcCode[6:2] <= exp_code and EXL <= 1.
- BadVAddr <= exp_badvaddr only when exp_code is 4 or 5.
- redirect_valid=1 and redirect_pc = BEV ? VEC_BOOT : VEC_NORM, both combinational in the same cycle.

ERET (exp_eret=1, exp_valid=0):
- EXL <= 0.
- redirect_valid=1, redirect_pc=EPC (current value).

Simultaneous events:
- exp_valid beats exp_eret.
- Both beat a same-cycle MTC0 to any field the exception or ERET updates; the MTC0 is dropped for those fields only.
- An MTC0 to an unrelated register in the same cycle still takes effect.

Reset mid-operation:
- Reset returns all state to reset values in the next cycle regardless of pending events.

Test Plan:
- Reset, read 8'h60 and 8'h68 -> 32'h0040_0000 and 0. MTC0 Status 32'hFFFF_FFFF, read -> 32'h0040_FF03.
- MTC0 Compare=5, MTC0 Count=0, run 12 cycles -> TI=1 and Cause[15]=1. With Status=32'h0000_8001, int_req=1. MTC0 Compare=100 -> TI=0 next cycle and int_req=0.
- exp_valid, exp_code=4, exp_pc=32'h8000_1004, exp_bd=1, exp_badvaddr=32'h1233 -> same cycle redirect_pc=32'hBFC0_0380. Next cycle EPC=32'h8000_1000, BD=1, ExcCode=4, BadVAddr=32'h1233, EXL=1.
- Second exception (code 12, pc 32'h8000_2000) while EXL=1 -> EPC stays 32'h8000_1000, ExcCode=12.
- exp_eret -> redirect_pc=32'h8000_1000 and EXL=0 next cycle. exp_eret together with exp_valid -> exception vector taken, EXL stays 1.
- hw_int=6'b000010, IM=8'h08, IE=1 -> int_req=1. Then set EXL=1 via MTC0 -> int_req=0. Also: Count=32'hFFFF_FFFF wraps to 0 after 2 cycles.

Source files
------------

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: BadVAddr/Count/Compare/Status/Cause/EPC, timer interrupt,
// exception entry and ERET, and the fetch redirect that goes with them.
module cp0_regfile #(
    parameter logic [31:0] VEC_BOOT = 32'hBFC0_0380,
    parameter logic [31:0] VEC_NORM = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cop0_addr,
    input  logic        cop0_wen,
    input  logic [31:0] cop0_wdata,
    output logic [31:0] cop0_data,
    input  logic        exp_valid,
    input  logic [4:0]  exp_code,
    input  logic [31:0] exp_pc,
    input  logic        exp_bd,
    input  logic [31:0] exp_badvaddr,
    input  logic        exp_eret,
    input  logic [5:0]  hw_int,
    output logic        int_req,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] status_o,
    output logic [31:0] epc_o
);
    localparam logic [7:0] A_BVA = 8'h40;
    localparam logic [7:0] A_CNT = 8'h48;
    localparam logic [7:0] A_CMP = 8'h58;
    localparam logic [7:0] A_ST  = 8'h60;
    localparam logic [7:0] A_CA  = 8'h68;
    localparam logic [7:0] A_EPC = 8'h70;

    logic [31:0] badvaddr, count, compare, epc;
    logic        phase, ti, bd, exl, ie;
    logic [7:0]  im;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code;
    logic [31:0] status, cause;
    logic        wr_cnt, wr_cmp, wr_st, wr_ca, wr_epc;
    logic        ti_nxt;

    assign status = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    assign cause  = {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, exc_code, 2'b0};

    assign wr_cnt = cop0_wen && (cop0_addr == A_CNT);
    assign wr_cmp = cop0_wen && (cop0_addr == A_CMP);
    assign wr_st  = cop0_wen && (cop0_addr == A_ST);
    assign wr_ca  = cop0_wen && (cop0_addr == A_CA);
    assign wr_epc = cop0_wen && (cop0_addr == A_EPC);

    // Compare write beats a same-cycle match; IP[15] tracks the new TI value.
    always_comb begin
        ti_nxt = ti;
        if (wr_cmp)
            ti_nxt = 1'b0;
        else if (count == compare)
            ti_nxt = 1'b1;
    end

    always_comb begin
        cop0_data = 32'b0;
        case (cop0_addr)
            A_BVA:   cop0_data = badvaddr;
            A_CNT:   cop0_data = count;
            A_CMP:   cop0_data = compare;
            A_ST:    cop0_data = status;
            A_CA:    cop0_data = cause;
            A_EPC:   cop0_data = epc;
            default: cop0_data = 32'b0;
        endcase
    end

    always_comb begin
        redirect_valid = !rst && (exp_valid || exp_eret);
        redirect_pc    = epc;
        if (exp_valid)
            redirect_pc = status[22] ? VEC_BOOT : VEC_NORM;
    end

    assign int_req  = ie && !exl && |(cause[15:8] & im);
    assign status_o = status;
    assign epc_o    = epc;

    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr <= 32'b0;
            count    <= 32'b0;
            compare  <= 32'b0;
            epc      <= 32'b0;
            phase    <= 1'b0;
            ti       <= 1'b0;
            bd       <= 1'b0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            im       <= 8'b0;
            ip_hw    <= 6'b0;
            ip_sw    <= 2'b0;
            exc_code <= 5'b0;
        end else begin
            phase <= ~phase;
            if (phase)
                count <= count + 32'd1;
            if (wr_cnt) begin
                count <= cop0_wdata;
                phase <= 1'b0;
            end
            if (wr_cmp)
                compare <= cop0_wdata;
            ti    <= ti_nxt;
            ip_hw <= {hw_int[5] | ti_nxt, hw_int[4:0]};

            if (wr_st) begin
                im  <= cop0_wdata[15:8];
                exl <= cop0_wdata[1];
                ie  <= cop0_wdata[0];
            end
            if (wr_ca)
                ip_sw <= cop0_wdata[9:8];
            if (wr_epc)
                epc <= cop0_wdata;

            // Later assignments override the MTC0 only on the fields the event owns.
            if (exp_valid) begin
                exc_code <= exp_code;
                exl      <= 1'b1;
                if (!exl) begin
                    epc <= exp_bd ? exp_pc - 32'd4 : exp_pc;
                    bd  <= exp_bd;
                end
                if (exp_code == 5'd4 || exp_code == 5'd5)
                    badvaddr <= exp_badvaddr;
            end else if (exp_eret) begin
                exl <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cp0_regfile.sv
// Directed vector bench for cp0_regfile: per-cycle stimulus records with same-cycle
// redirect/int_req expectations and a register read-back after the clock edge.
module tb_cp0_regfile;
    localparam logic [7:0] A_BVA = 8'h40;
    localparam logic [7:0] A_CNT = 8'h48;
    localparam logic [7:0] A_CMP = 8'h58;
    localparam logic [7:0] A_ST  = 8'h60;
    localparam logic [7:0] A_CA  = 8'h68;
    localparam logic [7:0] A_EPC = 8'h70;
    localparam logic [31:0] VB   = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cop0_addr;
    logic        cop0_wen;
    logic [31:0] cop0_wdata;
    logic [31:0] cop0_data;
    logic        exp_valid;
    logic [4:0]  exp_code;
    logic [31:0] exp_pc;
    logic        exp_bd;
    logic [31:0] exp_badvaddr;
    logic        exp_eret;
    logic [5:0]  hw_int;
    logic        int_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] status_o;
    logic [31:0] epc_o;

    cp0_regfile dut (
        .clk(clk), .rst(rst), .cop0_addr(cop0_addr), .cop0_wen(cop0_wen),
        .cop0_wdata(cop0_wdata), .cop0_data(cop0_data), .exp_valid(exp_valid),
        .exp_code(exp_code), .exp_pc(exp_pc), .exp_bd(exp_bd),
        .exp_badvaddr(exp_badvaddr), .exp_eret(exp_eret), .hw_int(hw_int),
        .int_req(int_req), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .status_o(status_o), .epc_o(epc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        ev;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        bd;
        logic [31:0] bva;
        logic        eret;
        logic [5:0]  hw;
        logic        rv;
        logic [31:0] rpc;
        logic        ci;
        logic        ir;
        logic [7:0]  raddr;
        logic [31:0] rdata;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int step     = 0;
    vec_t tbl[$];

    function automatic vec_t v(input logic wen, input logic [7:0] addr, input logic [31:0] wdata,
                               input logic ev, input logic [4:0] code, input logic [31:0] pc,
                               input logic bd, input logic [31:0] bva, input logic eret,
                               input logic [5:0] hw, input logic rv, input logic [31:0] rpc,
                               input logic ci, input logic ir, input logic [7:0] raddr,
                               input logic [31:0] rdata);
        vec_t r;
        r.wen = wen; r.addr = addr; r.wdata = wdata; r.ev = ev; r.code = code; r.pc = pc;
        r.bd = bd; r.bva = bva; r.eret = eret; r.hw = hw; r.rv = rv; r.rpc = rpc;
        r.ci = ci; r.ir = ir; r.raddr = raddr; r.rdata = rdata;
        return r;
    endfunction

    // Shorthands: plain MTC0, and a read-only idle cycle.
    function automatic vec_t mt(input logic [7:0] a, input logic [31:0] d, input logic [5:0] hw,
                                input logic ci, input logic ir, input logic [7:0] ra,
                                input logic [31:0] rd);
        return v(1, a, d, 0, 0, 0, 0, 0, 0, hw, 0, 0, ci, ir, ra, rd);
    endfunction

    function automatic vec_t nop(input logic [5:0] hw, input logic ci, input logic ir,
                                 input logic [7:0] ra, input logic [31:0] rd);
        return v(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, hw, 0, 0, ci, ir, ra, rd);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h expected=%h", nm, step, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cop0_wen = 0; cop0_wdata = 0; exp_valid = 0; exp_code = 0; exp_pc = 0;
        exp_bd = 0; exp_badvaddr = 0; exp_eret = 0;
    endtask

    task automatic apply(input vec_t t);
        @(negedge clk);
        cop0_wen = t.wen; cop0_addr = t.addr; cop0_wdata = t.wdata;
        exp_valid = t.ev; exp_code = t.code; exp_pc = t.pc; exp_bd = t.bd;
        exp_badvaddr = t.bva; exp_eret = t.eret; hw_int = t.hw;
        #1;
        chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, t.rv});
        if (t.rv) chk("redirect_pc", redirect_pc, t.rpc);
        if (t.ci) chk("int_req", {31'b0, int_req}, {31'b0, t.ir});
        @(posedge clk);
        #1;
        idle_inputs();
        cop0_addr = t.raddr;
        #1;
        chk("cop0_data", cop0_data, t.rdata);
        step++;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
        cop0_addr = a;
        #1;
        chk(nm, cop0_data, exp);
    endtask

    initial begin
        rst = 1; hw_int = 0; cop0_addr = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rd_chk("rst_status", A_ST, 32'h0040_0000);
        rd_chk("rst_cause", A_CA, 32'h0);
        rd_chk("rst_epc", A_EPC, 32'h0);
        rd_chk("rst_count", A_CNT, 32'h0);
        rd_chk("rst_bva", A_BVA, 32'h0);
        chk("rst_int_req", {31'b0, int_req}, 32'h0);
        chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
        chk("rst_status_o", status_o, 32'h0040_0000);
        @(negedge clk);
        rst = 0;

        // Status write mask, then timer: Compare=5, Count=0 -> TI after 11 edges.
        tbl.push_back(mt(A_ST,  32'hFFFF_FFFF, 0, 1, 0, A_ST,  32'h0040_FF03));
        tbl.push_back(mt(A_CMP, 32'd5,         0, 1, 0, A_CMP, 32'd5));
        tbl.push_back(mt(A_CNT, 32'd0,         0, 0, 0, A_CNT, 32'd0));
        tbl.push_back(mt(A_ST,  32'h0000_8001, 0, 0, 0, A_ST,  32'h0040_8001));
        tbl.push_back(nop(0, 0, 0, A_CNT, 32'd1));
        for (int i = 0; i < 6; i++) tbl.push_back(nop(0, 1, 0, A_CA, 32'h0));
        tbl.push_back(nop(0, 0, 0, A_CNT, 32'd4));
        tbl.push_back(nop(0, 1, 0, A_CNT, 32'd5));
        tbl.push_back(nop(0, 1, 0, A_CA, 32'h4000_8000));
        tbl.push_back(mt(A_CMP, 32'd100, 0, 1, 1, A_CA, 32'h0));
        tbl.push_back(nop(0, 1, 0, A_CMP, 32'd100));
        // Exceptions: delay-slot AdEL, nested Ov, ERET, ERET+exception.
        tbl.push_back(v(0, 0, 0, 1, 5'd4, 32'h8000_1004, 1, 32'h1233, 0, 0, 1, VB, 0, 0, A_EPC, 32'h8000_1000));
        tbl.push_back(nop(0, 0, 0, A_CA, 32'h8000_0010));
        tbl.push_back(nop(0, 0, 0, A_BVA, 32'h0000_1233));
        tbl.push_back(nop(0, 1, 0, A_ST, 32'h0040_8003));
        tbl.push_back(v(0, 0, 0, 1, 5'd12, 32'h8000_2000, 0, 32'hDEAD, 0, 0, 1, VB, 0, 0, A_EPC, 32'h8000_1000));
        tbl.push_back(nop(0, 0, 0, A_CA, 32'h8000_0030));
        tbl.push_back(nop(0, 0, 0, A_BVA, 32'h0000_1233));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h8000_1000, 0, 0, A_ST, 32'h0040_8001));
        tbl.push_back(v(0, 0, 0, 1, 5'd8, 32'h8000_3000, 0, 0, 1, 0, 1, VB, 0, 0, A_ST, 32'h0040_8003));
        tbl.push_back(nop(0, 0, 0, A_EPC, 32'h8000_3000));
        tbl.push_back(nop(0, 0, 0, A_CA, 32'h0000_0020));
        // Same-cycle MTC0 against exception/ERET.
        tbl.push_back(v(1, A_ST, 32'h0000_FF01, 1, 5'd9, 32'h8000_4000, 0, 0, 0, 0, 1, VB, 0, 0, A_ST, 32'h0040_FF03));
        tbl.push_back(v(1, A_CMP, 32'h200, 1, 5'd10, 32'h8000_5000, 0, 0, 0, 0, 1, VB, 0, 0, A_CMP, 32'h200));
        tbl.push_back(v(1, A_ST, 32'h0000_0003, 0, 0, 0, 0, 0, 1, 0, 1, 32'h8000_3000, 0, 0, A_ST, 32'h0040_0001));
        // Unmapped address, Cause write mask, EPC write.
        tbl.push_back(mt(8'h50, 32'hFFFF, 0, 0, 0, 8'h50, 32'h0));
        tbl.push_back(nop(0, 0, 0, A_EPC, 32'h8000_3000));
        tbl.push_back(mt(A_CA, 32'hFFFF_FFFF, 0, 1, 0, A_CA, 32'h0000_0328));
        tbl.push_back(mt(A_EPC, 32'h1234_5678, 0, 1, 0, A_EPC, 32'h1234_5678));
        tbl.push_back(mt(A_CA, 32'h0, 0, 0, 0, A_CA, 32'h0000_0028));
        // Hardware interrupt line 1 with IM=8'h08, then masked by EXL.
        tbl.push_back(mt(A_ST, 32'h0000_0801, 6'b000010, 1, 0, A_CA, 32'h0000_0828));
        tbl.push_back(mt(A_ST, 32'h0000_0803, 6'b000010, 1, 1, A_ST, 32'h0040_0803));
        tbl.push_back(nop(6'b000010, 1, 0, A_ST, 32'h0040_0803));
        // Count wrap.
        tbl.push_back(mt(A_CNT, 32'hFFFF_FFFF, 0, 0, 0, A_CNT, 32'hFFFF_FFFF));
        tbl.push_back(nop(0, 0, 0, A_CNT, 32'hFFFF_FFFF));
        tbl.push_back(nop(0, 1, 0, A_CNT, 32'h0));

        foreach (tbl[i]) apply(tbl[i]);

        // Compare write colliding with a match: clear wins, TI sets one cycle later.
        apply(mt(A_CMP, 32'h50, 0, 0, 0, A_CMP, 32'h50));
        apply(mt(A_CNT, 32'h50, 0, 0, 0, A_CNT, 32'h50));
        apply(mt(A_CMP, 32'h50, 0, 0, 0, A_CA, 32'h0000_0028));
        apply(nop(0, 0, 0, A_CA, 32'h4000_8028));

        // Reset arriving together with an exception and an MTC0.
        @(negedge clk);
        rst = 1; exp_valid = 1; exp_code = 5'd4; exp_pc = 32'h8000_9000; exp_badvaddr = 32'h77;
        cop0_wen = 1; cop0_addr = A_EPC; cop0_wdata = 32'hAAAA_AAAA;
        @(posedge clk);
        #1;
        idle_inputs();
        rd_chk("midrst_status", A_ST, 32'h0040_0000);
        rd_chk("midrst_epc", A_EPC, 32'h0);
        rd_chk("midrst_cause", A_CA, 32'h0);
        rd_chk("midrst_bva", A_BVA, 32'h0);
        rd_chk("midrst_compare", A_CMP, 32'h0);
        chk("midrst_int_req", {31'b0, int_req}, 32'h0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
